// File: rtl/sa_request_gen_if.sv
// Request/grant, VC buffer and crossbar signals between one input port's
// requester and the switch allocator / VC buffers / crossbar around it.
interface sa_request_gen_if #(
  parameter int NUM_PORTS = 4,
  parameter int NUM_VCS   = 4
);
  localparam int PW = $clog2(NUM_PORTS);

  logic [NUM_VCS-1:0]          vc_valid;
  logic [NUM_VCS-1:0][PW-1:0]  vc_out_port;
  logic [NUM_PORTS-1:0]        port_grant;
  logic [NUM_PORTS-1:0]        credit_return;
  logic [NUM_PORTS-1:0]        port_request;
  logic [NUM_VCS-1:0]          vc_dequeue;
  logic                        xbar_valid;
  logic [PW-1:0]               xbar_out_port;
  logic                        protocol_error;

  modport master (
    input  vc_valid, vc_out_port, port_grant, credit_return,
    output port_request, vc_dequeue, xbar_valid, xbar_out_port, protocol_error
  );

  modport slave (
    output vc_valid, vc_out_port, port_grant, credit_return,
    input  port_request, vc_dequeue, xbar_valid, xbar_out_port, protocol_error
  );
endinterface

// File: rtl/sa_request_gen.sv
// Per-input-port switch-allocator requester: round-robin VC pick, one-hot
// output request, dequeue/crossbar pulse on grant, per-output credit tracking.
module sa_request_gen #(
  parameter int NUM_PORTS    = 4,
  parameter int NUM_VCS      = 4,
  parameter int CREDIT_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  sa_request_gen_if.master  bus
);
  localparam int PW = $clog2(NUM_PORTS);
  localparam int CW = $clog2(CREDIT_DEPTH + 1);
  localparam int VW = $clog2(NUM_VCS);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(CREDIT_DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DEQ} state_t;

  state_t          state;
  logic [VW-1:0]   rr;
  logic [VW-1:0]   sel_vc;
  logic [PW-1:0]   sel_port;
  logic [CW-1:0]   credit [NUM_PORTS];

  logic            cand_found;
  logic [VW-1:0]   cand_vc;
  logic [VW-1:0]   vi;
  logic            grant_accept;
  logic            grant_spurious;
  logic [NUM_PORTS-1:0] dec_vec;
  logic            credit_overflow;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic [PW-1:0] p);
    port_onehot    = '0;
    port_onehot[p] = 1'b1;
  endfunction

  function automatic logic [NUM_VCS-1:0] vc_onehot(input logic [VW-1:0] v);
    vc_onehot    = '0;
    vc_onehot[v] = 1'b1;
  endfunction

  // First eligible VC searching upward from rr, wrapping.
  // NOTE: every combinational output gets a default before the loop so no latch is inferred.
  always_comb begin
    cand_found = 1'b0;
    cand_vc    = '0;
    vi         = '0;
    for (int i = 0; i < NUM_VCS; i++) begin
      vi = VW'((int'(rr) + i) % NUM_VCS);
      if (!cand_found && bus.vc_valid[vi] && credit[bus.vc_out_port[vi]] != '0) begin
        cand_found = 1'b1;
        cand_vc    = vi;
      end
    end
  end

  // In REQ the registered request is exactly onehot(sel_port), so a matching
  // grant identifies the port whose credit is consumed.
  assign grant_accept   = (state == REQ) && (bus.port_grant == bus.port_request);
  assign grant_spurious = (bus.port_grant != '0) &&
                          ((state != REQ) || (bus.port_grant != bus.port_request));
  assign dec_vec        = grant_accept ? bus.port_request : '0;

  always_comb begin
    credit_overflow = 1'b0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (bus.credit_return[p] && !dec_vec[p] && credit[p] == CREDIT_MAX)
        credit_overflow = 1'b1;
    end
  end

  // NOTE: the credit counters are architectural state, so unlike a data RAM they must be reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int p = 0; p < NUM_PORTS; p++) credit[p] <= CREDIT_MAX;
    end else begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        case ({dec_vec[p], bus.credit_return[p]})
          2'b10:   credit[p] <= credit[p] - CW'(1);
          2'b01:   if (credit[p] != CREDIT_MAX) credit[p] <= credit[p] + CW'(1);
          default: ;
        endcase
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      rr                 <= '0;
      sel_vc             <= '0;
      sel_port           <= '0;
      bus.port_request   <= '0;
      bus.vc_dequeue     <= '0;
      bus.xbar_valid     <= 1'b0;
      bus.xbar_out_port  <= '0;
      bus.protocol_error <= 1'b0;
    end else begin
      if (grant_spurious || credit_overflow) bus.protocol_error <= 1'b1;

      case (state)
        IDLE: begin
          if (cand_found) begin
            sel_vc           <= cand_vc;
            sel_port         <= bus.vc_out_port[cand_vc];
            bus.port_request <= port_onehot(bus.vc_out_port[cand_vc]);
            state            <= REQ;
          end
        end

        REQ: begin
          if (grant_accept) begin
            bus.port_request  <= '0;
            bus.vc_dequeue    <= vc_onehot(sel_vc);
            bus.xbar_valid    <= 1'b1;
            bus.xbar_out_port <= sel_port;
            rr                <= VW'((int'(sel_vc) + 1) % NUM_VCS);
            state             <= DEQ;
          end else if (!bus.vc_valid[sel_vc]) begin
            // Flit withdrawn: abandon without moving the pointer.
            bus.port_request <= '0;
            state            <= IDLE;
          end
        end

        DEQ: begin
          bus.vc_dequeue    <= '0;
          bus.xbar_valid    <= 1'b0;
          bus.xbar_out_port <= '0;
          state             <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sa_request_gen.sv
// Directed bench for sa_request_gen: one task per scenario, inline checks.
module tb_sa_request_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  sa_request_gen_if #(.NUM_PORTS(4), .NUM_VCS(4)) bus ();

  sa_request_gen #(.NUM_PORTS(4), .NUM_VCS(4), .CREDIT_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    #100000;
    $display("FAIL watchdog: sim time %0t exceeded limit", $time);
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next active edge; sample and drive there.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    bus.vc_valid      = '0;
    bus.vc_out_port   = '0;
    bus.port_grant    = '0;
    bus.credit_return = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    checks++; if (bus.port_request !== 4'b0000) begin errors++; $display("FAIL reset_req: got %b want 0000", bus.port_request); end
    checks++; if (bus.vc_dequeue !== 4'b0000) begin errors++; $display("FAIL reset_deq: got %b want 0000", bus.vc_dequeue); end
    checks++; if (bus.xbar_valid !== 1'b0 || bus.xbar_out_port !== 2'd0) begin errors++; $display("FAIL reset_xbar: got %b/%0d want 0/0", bus.xbar_valid, bus.xbar_out_port); end
    checks++; if (bus.protocol_error !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.protocol_error); end
    for (int p = 0; p < 4; p++) begin
      checks++; if (dut.credit[p] !== 3'd4) begin errors++; $display("FAIL reset_credit%0d: got %0d want 4", p, dut.credit[p]); end
    end
  endtask

  task automatic test_single_flit;
    do_reset();
    bus.vc_valid = 4'b0001;
    bus.vc_out_port[0] = 2'd2;
    tick();
    checks++; if (bus.port_request !== 4'b0100) begin errors++; $display("FAIL single_req: got %b want 0100", bus.port_request); end
    checks++; if (bus.vc_dequeue !== 4'b0000) begin errors++; $display("FAIL single_nodeq_in_req: got %b want 0000", bus.vc_dequeue); end
    bus.port_grant = 4'b0100;
    tick();
    checks++; if (bus.port_request !== 4'b0000) begin errors++; $display("FAIL single_req_drop: got %b want 0000", bus.port_request); end
    checks++; if (bus.vc_dequeue !== 4'b0001) begin errors++; $display("FAIL single_deq: got %b want 0001", bus.vc_dequeue); end
    checks++; if (bus.xbar_valid !== 1'b1 || bus.xbar_out_port !== 2'd2) begin errors++; $display("FAIL single_xbar: got %b/%0d want 1/2", bus.xbar_valid, bus.xbar_out_port); end
    checks++; if (dut.credit[2] !== 3'd3) begin errors++; $display("FAIL single_credit: got %0d want 3", dut.credit[2]); end
    bus.port_grant = '0;
    bus.vc_valid   = '0;
    tick();
    checks++; if (bus.vc_dequeue !== 4'b0000 || bus.xbar_valid !== 1'b0) begin errors++; $display("FAIL single_idle: got deq=%b xv=%b want 0000/0", bus.vc_dequeue, bus.xbar_valid); end
    checks++; if (dut.rr !== 2'd1) begin errors++; $display("FAIL single_rr: got %0d want 1", dut.rr); end
    checks++; if (bus.protocol_error !== 1'b0) begin errors++; $display("FAIL single_err: got %b want 0", bus.protocol_error); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_deq [5];
    exp_deq[0] = 4'b0001; exp_deq[1] = 4'b0010; exp_deq[2] = 4'b0100;
    exp_deq[3] = 4'b1000; exp_deq[4] = 4'b0001;
    do_reset();
    bus.vc_valid    = 4'b1111;
    bus.vc_out_port = {2'd1, 2'd1, 2'd1, 2'd1};
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++; if (bus.port_request !== 4'b0010) begin errors++; $display("FAIL rr_req%0d: got %b want 0010", k, bus.port_request); end
      bus.port_grant = 4'b0010;
      tick();
      checks++; if (bus.vc_dequeue !== exp_deq[k]) begin errors++; $display("FAIL rr_deq%0d: got %b want %b", k, bus.vc_dequeue, exp_deq[k]); end
      bus.port_grant = '0;
      tick();
    end
    checks++; if (dut.credit[1] !== 3'd0) begin errors++; $display("FAIL rr_credit_empty: got %0d want 0", dut.credit[1]); end
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++; if (bus.port_request !== 4'b0000) begin errors++; $display("FAIL rr_starved%0d: got %b want 0000", k, bus.port_request); end
    end
    bus.credit_return = 4'b0010;
    tick();
    bus.credit_return = '0;
    checks++; if (dut.credit[1] !== 3'd1) begin errors++; $display("FAIL rr_credit_ret: got %0d want 1", dut.credit[1]); end
    checks++; if (bus.port_request !== 4'b0000) begin errors++; $display("FAIL rr_req_before_credit: got %b want 0000", bus.port_request); end
    tick();
    checks++; if (bus.port_request !== 4'b0010) begin errors++; $display("FAIL rr_req4: got %b want 0010", bus.port_request); end
    bus.port_grant = 4'b0010;
    tick();
    checks++; if (bus.vc_dequeue !== exp_deq[4]) begin errors++; $display("FAIL rr_deq4: got %b want %b", bus.vc_dequeue, exp_deq[4]); end
    bus.port_grant = '0;
    bus.vc_valid   = '0;
    tick();
  endtask

  task automatic test_held_request;
    do_reset();
    bus.vc_valid = 4'b0010;
    bus.vc_out_port[1] = 2'd3;
    tick();
    for (int i = 0; i < 6; i++) begin
      checks++; if (bus.port_request !== 4'b1000 || bus.vc_dequeue !== 4'b0000) begin errors++; $display("FAIL held_cycle%0d: got req=%b deq=%b want 1000/0000", i, bus.port_request, bus.vc_dequeue); end
      if (i == 5) bus.port_grant = 4'b1000;
      tick();
    end
    checks++; if (bus.vc_dequeue !== 4'b0010 || bus.xbar_out_port !== 2'd3) begin errors++; $display("FAIL held_deq: got deq=%b port=%0d want 0010/3", bus.vc_dequeue, bus.xbar_out_port); end
    bus.port_grant = '0;
    bus.vc_valid   = '0;
    tick();
  endtask

  task automatic test_withdraw;
    do_reset();
    bus.vc_valid    = 4'b0100;
    bus.vc_out_port = {2'd0, 2'd0, 2'd0, 2'd0};
    tick();
    checks++; if (bus.port_request !== 4'b0001) begin errors++; $display("FAIL wd_req: got %b want 0001", bus.port_request); end
    bus.vc_valid = 4'b0000;
    tick();
    checks++; if (bus.port_request !== 4'b0000 || bus.vc_dequeue !== 4'b0000) begin errors++; $display("FAIL wd_idle: got req=%b deq=%b want 0000/0000", bus.port_request, bus.vc_dequeue); end
    checks++; if (dut.rr !== 2'd0 || dut.credit[0] !== 3'd4) begin errors++; $display("FAIL wd_state: got rr=%0d credit=%0d want 0/4", dut.rr, dut.credit[0]); end
    // From pointer 0, VC1 wins over VC3; a moved pointer would pick VC3.
    bus.vc_valid = 4'b1010;
    tick();
    bus.port_grant = 4'b0001;
    tick();
    checks++; if (bus.vc_dequeue !== 4'b0010) begin errors++; $display("FAIL wd_next_sel: got %b want 0010", bus.vc_dequeue); end
    checks++; if (bus.protocol_error !== 1'b0) begin errors++; $display("FAIL wd_err: got %b want 0", bus.protocol_error); end
    bus.port_grant = '0;
    bus.vc_valid   = '0;
    tick();
  endtask

  task automatic test_credit_corners;
    do_reset();
    bus.credit_return = 4'b0001;
    tick();
    bus.credit_return = '0;
    checks++; if (dut.credit[0] !== 3'd4) begin errors++; $display("FAIL cc_saturate: got %0d want 4", dut.credit[0]); end
    checks++; if (bus.protocol_error !== 1'b1) begin errors++; $display("FAIL cc_overflow_err: got %b want 1", bus.protocol_error); end
    do_reset();
    bus.vc_valid = 4'b0001;
    bus.vc_out_port[0] = 2'd0;
    tick();
    bus.port_grant    = 4'b0001;
    bus.credit_return = 4'b0001;
    tick();
    bus.port_grant    = '0;
    bus.credit_return = '0;
    checks++; if (dut.credit[0] !== 3'd4) begin errors++; $display("FAIL cc_grant_and_ret: got %0d want 4", dut.credit[0]); end
    checks++; if (bus.protocol_error !== 1'b0 || bus.vc_dequeue !== 4'b0001) begin errors++; $display("FAIL cc_grant_and_ret_flags: got err=%b deq=%b want 0/0001", bus.protocol_error, bus.vc_dequeue); end
    bus.vc_valid = '0;
    tick();
  endtask

  task automatic test_spurious_grant;
    do_reset();
    bus.port_grant = 4'b0010;
    tick();
    bus.port_grant = '0;
    checks++; if (bus.protocol_error !== 1'b1 || bus.vc_dequeue !== 4'b0000) begin errors++; $display("FAIL sp_idle: got err=%b deq=%b want 1/0000", bus.protocol_error, bus.vc_dequeue); end
    tick();
    checks++; if (bus.protocol_error !== 1'b1) begin errors++; $display("FAIL sp_sticky: got %b want 1", bus.protocol_error); end
    do_reset();
    bus.vc_valid = 4'b0001;
    bus.vc_out_port[0] = 2'd2;
    tick();
    bus.port_grant = 4'b0010;
    tick();
    checks++; if (bus.protocol_error !== 1'b1 || bus.port_request !== 4'b0100 || bus.vc_dequeue !== 4'b0000) begin errors++; $display("FAIL sp_req_mismatch: got err=%b req=%b deq=%b want 1/0100/0000", bus.protocol_error, bus.port_request, bus.vc_dequeue); end
    checks++; if (dut.credit[1] !== 3'd4 || dut.credit[2] !== 3'd4) begin errors++; $display("FAIL sp_credit: got c1=%0d c2=%0d want 4/4", dut.credit[1], dut.credit[2]); end
    bus.port_grant = 4'b0100;
    tick();
    checks++; if (bus.vc_dequeue !== 4'b0001) begin errors++; $display("FAIL sp_recover_deq: got %b want 0001", bus.vc_dequeue); end
    bus.port_grant = '0;
    bus.vc_valid   = '0;
    tick();
  endtask

  task automatic test_reset_mid_deq;
    do_reset();
    bus.vc_valid = 4'b0001;
    bus.vc_out_port[0] = 2'd2;
    tick();
    bus.port_grant = 4'b0100;
    tick();
    checks++; if (bus.xbar_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_deq: got %b want 1", bus.xbar_valid); end
    #2;
    reset = 1'b1;
    #1;
    checks++; if (bus.vc_dequeue !== 4'b0000 || bus.xbar_valid !== 1'b0 || bus.xbar_out_port !== 2'd0 || bus.port_request !== 4'b0000) begin errors++; $display("FAIL rst_async_outputs: got deq=%b xv=%b xp=%0d req=%b want all 0", bus.vc_dequeue, bus.xbar_valid, bus.xbar_out_port, bus.port_request); end
    checks++; if (dut.credit[2] !== 3'd4 || dut.rr !== 2'd0) begin errors++; $display("FAIL rst_async_state: got credit=%0d rr=%0d want 4/0", dut.credit[2], dut.rr); end
    clear_inputs();
    #3;
    reset = 1'b0;
    tick();
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_single_flit();
    test_round_robin();
    test_held_request();
    test_withdraw();
    test_credit_corners();
    test_spurious_grant();
    test_reset_mid_deq();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
